// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver: off/on/blink/breathe from one shared counter
// Exports the counter MSB as heartbeat and a registered rollover pulse.
module led_pattern_gen #(
  parameter int NUM_LEDS  = 4,
  parameter int CTR_WIDTH = 24,
  parameter int PWM_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*NUM_LEDS-1:0] mode,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  heartbeat,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } led_mode_t;

  logic [CTR_WIDTH-1:0] ctr;
  logic [NUM_LEDS-1:0]  led_target;

  logic [PWM_BITS:0]    ramp_t;
  logic [PWM_BITS-1:0]  bright;
  logic [PWM_BITS-1:0]  pwm_slot;
  logic                 breathe_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr  <= '0;
      wrap <= 1'b0;
    end else begin
      // wrap lands in the same cycle the counter reads zero after rolling over
      wrap <= en && (ctr == {CTR_WIDTH{1'b1}});
      if (en) begin
        ctr <= ctr + 1'b1;
      end
    end
  end

  assign heartbeat = ctr[CTR_WIDTH-1];

  // Triangle brightness from the slow counter bits, compared against the fast PWM slot
  assign ramp_t     = ctr[CTR_WIDTH-1 -: PWM_BITS+1];
  assign bright     = ramp_t[PWM_BITS] ? ~ramp_t[PWM_BITS-1:0] : ramp_t[PWM_BITS-1:0];
  assign pwm_slot   = ctr[PWM_BITS-1:0];
  assign breathe_on = (pwm_slot < bright);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    localparam logic ODD_CHAN = ((i % 2) != 0);
    led_mode_t chan_mode;

    assign chan_mode = led_mode_t'(mode[2*i+1 -: 2]);

    always_comb begin
      led_target[i] = 1'b0;
      case (chan_mode)
        MODE_OFF:     led_target[i] = 1'b0;
        MODE_ON:      led_target[i] = 1'b1;
        MODE_BLINK:   led_target[i] = ctr[CTR_WIDTH-1] ^ ODD_CHAN;
        MODE_BREATHE: led_target[i] = breathe_on;
        default:      led_target[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_target;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen (2 LEDs, 8-bit counter)
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] mode;
  logic [1:0] led;
  logic       heartbeat;
  logic       wrap;

  int checks;
  int errors;

  logic [7:0] mctr;
  logic [7:0] prev;
  logic [1:0] frozen_led;
  int         first_high;
  int         h0 [32];
  int         h1 [32];
  int         tvals [6];
  int         bexp [6];

  led_pattern_gen #(
    .NUM_LEDS(2),
    .CTR_WIDTH(8),
    .PWM_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .led(led),
    .heartbeat(heartbeat),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 4'b0000;
    mctr = 8'h00;
    tvals = '{0, 3, 7, 8, 12, 15};
    bexp  = '{0, 3, 7, 7, 3, 0};

    #12;
    check("reset_led", led, 2'b00);
    check("reset_wrap", wrap, 1'b0);
    check("reset_hb", heartbeat, 1'b0);
    rst = 1'b0;

    // Static modes with the counter frozen at zero
    tick();
    mode = 4'b0101;
    #0;
    check("mode_latency_pre", led, 2'b00);
    tick();
    check("static_0101", led, 2'b11);
    check("static_wrap_frozen0", wrap, 1'b0);
    mode = 4'b0100;
    tick();
    check("static_0100", led, 2'b10);
    mode = 4'b0000;
    tick();
    check("static_0000", led, 2'b00);
    check("static_wrap_frozen0b", wrap, 1'b0);

    // Count to 0x5A with both LEDs on, then reset between edges
    mode = 4'b0101;
    en   = 1'b1;
    for (int k = 0; k < 90; k++) tick();
    check("count5a_led", led, 2'b11);
    check("count5a_hb", heartbeat, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_led", led, 2'b00);
    check("async_rst_wrap", wrap, 1'b0);
    check("async_rst_hb", heartbeat, 1'b0);
    #1 rst = 1'b0;
    mode = 4'b1010;
    mctr = 8'h00;

    // Blink: one full counter period, wrap expected only on the 256th edge
    first_high = -1;
    for (int k = 1; k <= 256; k++) begin
      prev = mctr;
      tick();
      mctr = mctr + 8'd1;
      check("blink_led", led, {~prev[7], prev[7]});
      check("blink_wrap", wrap, (mctr == 8'h00));
      check("blink_hb", heartbeat, mctr[7]);
      if (first_high < 0 && led[0]) first_high = k;
    end
    check("blink_first_high", first_high, 129);

    // Breathe: tally highs per 8-cycle PWM window over one counter period
    mode = 4'b1111;
    for (int w = 0; w < 32; w++) begin
      h0[w] = 0;
      h1[w] = 0;
    end
    for (int k = 0; k < 256; k++) begin
      prev = mctr;
      tick();
      mctr = mctr + 8'd1;
      h0[prev[7:3]] += int'(led[0]);
      h1[prev[7:3]] += int'(led[1]);
    end
    check("breathe_wrap_end", wrap, 1'b1);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("breathe_t%0d_w0_led0", tvals[j]), h0[2*tvals[j]], bexp[j]);
      check($sformatf("breathe_t%0d_w1_led0", tvals[j]), h0[2*tvals[j]+1], bexp[j]);
      check($sformatf("breathe_t%0d_led1", tvals[j]), h1[2*tvals[j]], bexp[j]);
    end

    // Run to 0xFF, then freeze
    mode = 4'b1010;
    for (int k = 0; k < 255; k++) tick();
    mctr = 8'hFF;
    check("pre_freeze_wrap", wrap, 1'b0);
    en = 1'b0;
    tick();
    frozen_led = led;
    check("freeze_led_first", led, 2'b01);
    for (int k = 0; k < 49; k++) begin
      tick();
      check("freeze_wrap", wrap, 1'b0);
      check("freeze_led", led, frozen_led);
      check("freeze_hb", heartbeat, 1'b1);
    end
    mode = 4'b0101;
    tick();
    check("freeze_mode_on", led, 2'b11);
    mode = 4'b0000;
    tick();
    check("freeze_mode_off", led, 2'b00);
    mode = 4'b1010;
    tick();
    check("freeze_blink_back", led, 2'b01);
    check("freeze_no_wrap", wrap, 1'b0);

    // Restore enable: rollover on the very next edge
    en = 1'b1;
    tick();
    check("restore_wrap", wrap, 1'b1);
    check("restore_hb", heartbeat, 1'b0);
    check("restore_led", led, 2'b01);
    tick();
    check("restore_wrap_drop", wrap, 1'b0);
    check("restore_led_next", led, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
